// File: rtl/strv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : strv32i_pkg
//  Description : Shared RV32I control-transfer encodings and the saturating
//                counter helper used by the branch predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package strv32i_pkg;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    // Conditional-branch func3 encodings, instr[14:12]
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Widest counter the helper supports; callers zero-extend into this.
    localparam int CTR_MAX_W = 16;

    // Step a counter one place towards i_max (i_up=1) or towards zero,
    // holding at either end.
    function automatic logic [CTR_MAX_W-1:0] ctr_saturate(
        input logic [CTR_MAX_W-1:0] i_ctr,
        input logic [CTR_MAX_W-1:0] i_max,
        input logic                 i_up
    );
        if (i_up) begin
            return (i_ctr >= i_max) ? i_ctr : i_ctr + 1'b1;
        end
        return (i_ctr == '0) ? i_ctr : i_ctr - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_compare.sv
`default_nettype none
// ============================================================================
//  Module      : branch_compare
//  Description : Combinational control-transfer outcome. Decides taken/not
//                taken from operands, opcode and func3, flags the reserved
//                BRANCH func3 codes, and marks legal conditional branches
//                (the only instructions that train the history table).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_compare
    import strv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_opcode,
    input  logic [2:0]      i_func3,
    output logic            o_taken,
    output logic            o_illegal,
    output logic            o_cond_branch
);

    logic w_taken;
    logic w_illegal;
    logic w_cond_branch;

    // Decode opcode/func3 and evaluate the selected comparison.
    always_comb begin
        w_taken       = 1'b0;
        w_illegal     = 1'b0;
        w_cond_branch = 1'b0;
        case (i_opcode)
            OPC_BRANCH: begin
                w_cond_branch = 1'b1;
                case (i_func3)
                    F3_BEQ:  w_taken = (i_rs1 == i_rs2);
                    F3_BNE:  w_taken = (i_rs1 != i_rs2);
                    F3_BLT:  w_taken = ($signed(i_rs1) <  $signed(i_rs2));
                    F3_BGE:  w_taken = ($signed(i_rs1) >= $signed(i_rs2));
                    F3_BLTU: w_taken = (i_rs1 <  i_rs2);
                    F3_BGEU: w_taken = (i_rs1 >= i_rs2);
                    default: begin
                        // 010/011 are reserved: never taken, never trained
                        w_illegal     = 1'b1;
                        w_cond_branch = 1'b0;
                    end
                endcase
            end
            OPC_JAL, OPC_JALR: w_taken = 1'b1;
            default: ;
        endcase
    end

    assign o_taken       = w_taken;
    assign o_illegal     = w_illegal;
    assign o_cond_branch = w_cond_branch;

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Bimodal branch predictor. Fetch reads a table of saturating
//                counters combinationally; execute resolves branches through
//                a one-deep registered result stage that reports the actual
//                direction, mispredicts and illegal encodings, and trains
//                the table on legal conditional branches.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import strv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CTR_W     = 2,
    parameter int CTR_INIT  = 1
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            pred_valid_in,
    input  logic [XLEN-1:0] pred_pc_in,
    output logic            pred_taken_out,
    input  logic            res_valid_in,
    input  logic [XLEN-1:0] res_pc_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      opcode_6_2_in,
    input  logic [2:0]      func3_in,
    input  logic            res_pred_taken_in,
    input  logic            flush_in,
    output logic            res_valid_out,
    output logic            branch_taken_out,
    output logic            mispredict_out,
    output logic            illegal_out
);

    localparam int                   c_DEPTH    = 2 ** BHT_IDX_W;
    localparam logic [CTR_W-1:0]     c_CTR_INIT = CTR_W'(CTR_INIT);
    localparam logic [CTR_MAX_W-1:0] c_CTR_MAX  = CTR_MAX_W'((1 << CTR_W) - 1);

    logic [CTR_W-1:0]     r_bht [c_DEPTH];
    logic                 r_res_valid;
    logic                 r_taken;
    logic                 r_mispredict;
    logic                 r_illegal;

    logic [BHT_IDX_W-1:0] w_pred_idx;
    logic [BHT_IDX_W-1:0] w_res_idx;
    logic                 w_taken;
    logic                 w_illegal;
    logic                 w_cond_branch;
    logic                 w_accept;
    logic                 w_update;
    logic [CTR_MAX_W-1:0] w_ctr_next_ext;
    logic [CTR_W-1:0]     w_ctr_next;
    logic                 w_unused;

    // Word-aligned PCs: drop the two byte-offset bits, keep the low index bits.
    assign w_pred_idx = pred_pc_in[BHT_IDX_W+1:2];
    assign w_res_idx  = res_pc_in[BHT_IDX_W+1:2];

    assign pred_taken_out = pred_valid_in & r_bht[w_pred_idx][CTR_W-1];

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .i_rs1         (rs1_in),
        .i_rs2         (rs2_in),
        .i_opcode      (opcode_6_2_in),
        .i_func3       (func3_in),
        .o_taken       (w_taken),
        .o_illegal     (w_illegal),
        .o_cond_branch (w_cond_branch)
    );

    assign w_accept = res_valid_in & ~flush_in;
    assign w_update = w_accept & w_cond_branch;

    assign w_ctr_next_ext = ctr_saturate(CTR_MAX_W'(r_bht[w_res_idx]), c_CTR_MAX, w_taken);
    assign w_ctr_next     = w_ctr_next_ext[CTR_W-1:0];

    // PC bits outside the index and the helper's headroom bits carry no information here.
    assign w_unused = ^{pred_pc_in[XLEN-1:BHT_IDX_W+2], pred_pc_in[1:0],
                        res_pc_in[XLEN-1:BHT_IDX_W+2], res_pc_in[1:0],
                        w_ctr_next_ext[CTR_MAX_W-1:CTR_W]};

    // History table: reset every counter, train only on accepted legal branches.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bht[i] <= c_CTR_INIT;
            end
        end else if (w_update) begin
            r_bht[w_res_idx] <= w_ctr_next;
        end
    end

    // One-deep result register; flags are qualified by valid so they read 0 when idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_res_valid  <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_res_valid  <= w_accept;
            r_taken      <= w_accept & w_taken;
            r_mispredict <= w_accept & (w_taken ^ res_pred_taken_in);
            r_illegal    <= w_accept & w_illegal;
        end
    end

    assign res_valid_out    = r_res_valid;
    assign branch_taken_out = r_taken;
    assign mispredict_out   = r_mispredict;
    assign illegal_out      = r_illegal;

endmodule
`default_nettype wire
